// File: rtl/xbar_scatter_pkg.sv
// Shared defaults and index-width helper for the xbar_scatter crossbar.
// Arbitration mode is selected by XBAR_SCATTER_RR_EN (see rtl/xbar_scatter_rr_arbiter.sv).
package xbar_scatter_pkg;

  localparam int unsigned ELEM_WIDTH_DEFAULT = 4;
  localparam int unsigned NUM_ELEM_DEFAULT   = 5;

  // Index width that never collapses to zero for a single-lane build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_scatter_rr_arbiter.sv
// Per-output arbiter: round-robin when XBAR_SCATTER_RR_EN is defined,
// fixed lowest-index priority otherwise. gnt_o is one-hot or zero.
module rr_arbiter
  import xbar_scatter_pkg::*;
#(
  parameter int unsigned NumReq = NUM_ELEM_DEFAULT
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o
);

  logic [NumReq-1:0] w_pick;
  logic              w_found;

`ifdef XBAR_SCATTER_RR_EN
  localparam int unsigned PtrW = idx_width(NumReq);

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_ptr_nxt;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_pick    = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!w_found && req_i[idx]) begin
        w_found     = 1'b1;
        w_pick[idx] = 1'b1;
        w_ptr_nxt   = (idx == NumReq - 1) ? '0 : PtrW'(idx + 1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_ptr <= '0;
    end else if (en_i && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk_i ^ arst_ni;

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_found && req_i[i]) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
      end
    end
  end
`endif

  assign gnt_o = en_i ? w_pick : '0;

endmodule

// File: rtl/xbar_scatter.sv
// Registered valid/ready scatter crossbar: each input names its output lane.
// Define XBAR_SCATTER_RR_EN for round-robin arbitration; default is fixed priority.
module xbar_scatter
  import xbar_scatter_pkg::*;
#(
  parameter  int unsigned ElemWidth = ELEM_WIDTH_DEFAULT,
  parameter  int unsigned NumElem   = NUM_ELEM_DEFAULT,
  localparam int unsigned DW        = idx_width(NumElem)
) (
  input  logic                               clk_i,
  input  logic                               arst_ni,
  input  logic [NumElem-1:0][DW-1:0]         in_dest_i,
  input  logic [NumElem-1:0][ElemWidth-1:0]  in_data_i,
  input  logic [NumElem-1:0]                 in_valid_i,
  output logic [NumElem-1:0]                 in_ready_o,
  output logic [NumElem-1:0][ElemWidth-1:0]  out_data_o,
  output logic [NumElem-1:0]                 out_valid_o,
  input  logic [NumElem-1:0]                 out_ready_i,
  output logic [NumElem-1:0]                 drop_o
);

  // Request and grant matrices are indexed [output][input].
  logic [NumElem-1:0]                w_req [NumElem];
  logic [NumElem-1:0]                w_gnt [NumElem];
  logic [NumElem-1:0]                w_free;
  logic [NumElem-1:0]                w_drop;
  logic [NumElem-1:0]                w_granted;
  logic [NumElem-1:0]                w_any_gnt;
  logic [NumElem-1:0][ElemWidth-1:0] w_sel_data;
  logic [NumElem-1:0][ElemWidth-1:0] r_data;
  logic [NumElem-1:0]                r_valid;

  always_comb begin
    w_drop = '0;
    for (int unsigned j = 0; j < NumElem; j++) w_req[j] = '0;
    for (int unsigned i = 0; i < NumElem; i++) begin
      // Out-of-range destinations are accepted and discarded, never wrapped.
      if ({1'b0, in_dest_i[i]} >= (DW + 1)'(NumElem)) w_drop[i] = in_valid_i[i];
      for (int unsigned j = 0; j < NumElem; j++) begin
        w_req[j][i] = in_valid_i[i] && (in_dest_i[i] == DW'(j));
      end
    end
  end

  assign w_free = ~r_valid | out_ready_i;

  for (genvar g = 0; g < NumElem; g++) begin : g_arb
    rr_arbiter #(
      .NumReq(NumElem)
    ) u_arb (
      .clk_i  (clk_i),
      .arst_ni(arst_ni),
      .req_i  (w_req[g]),
      .en_i   (w_free[g]),
      .gnt_o  (w_gnt[g])
    );
  end

  always_comb begin
    w_granted  = '0;
    w_any_gnt  = '0;
    w_sel_data = '0;
    for (int unsigned j = 0; j < NumElem; j++) begin
      for (int unsigned i = 0; i < NumElem; i++) begin
        if (w_gnt[j][i]) begin
          w_granted[i]  = 1'b1;
          w_any_gnt[j]  = 1'b1;
          w_sel_data[j] = in_data_i[i];
        end
      end
    end
  end

  assign in_ready_o = arst_ni ? (w_granted | w_drop) : '0;
  assign drop_o     = arst_ni ? w_drop : '0;

  // NOTE: data slots are reset too because a zero output after reset is visible behaviour here.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int unsigned j = 0; j < NumElem; j++) begin
        if (w_any_gnt[j]) begin
          r_valid[j] <= 1'b1;
          r_data[j]  <= w_sel_data[j];
        end else if (w_free[j]) begin
          r_valid[j] <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;

endmodule

// File: tb/tb_xbar_scatter.sv
// Self-checking bench for xbar_scatter: directed scenarios plus random traffic
// against a lane-level reference model; follows XBAR_SCATTER_RR_EN like the DUT.
module tb_xbar_scatter;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int DW = 3;

  logic                    clk = 1'b0;
  logic                    arst_n;
  logic [N-1:0][DW-1:0]    in_dest;
  logic [N-1:0][W-1:0]     in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [N-1:0][W-1:0]     out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic [N-1:0]            drop;

  always #10 clk = ~clk;

  xbar_scatter #(
    .ElemWidth(W),
    .NumElem  (N)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .in_dest_i  (in_dest),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .drop_o     (drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one slot per output plus a round-robin pointer.
  logic         m_valid [N];
  logic [W-1:0] m_data  [N];
  int           m_ptr   [N];
  int           m_win   [N];
  logic [N-1:0] e_ready;
  logic [N-1:0] e_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_valid[j] = 1'b0;
      m_data[j]  = '0;
      m_ptr[j]   = 0;
      m_win[j]   = -1;
    end
  endfunction

  function automatic void model_comb();
    e_ready = '0;
    e_drop  = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && int'(in_dest[i]) >= N) begin
        e_ready[i] = 1'b1;
        e_drop[i]  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      m_win[j] = -1;
      if (!m_valid[j] || out_ready[j]) begin
        for (int k = 0; k < N; k++) begin
          int i;
`ifdef XBAR_SCATTER_RR_EN
          i = (m_ptr[j] + k) % N;
`else
          i = k;
`endif
          if (m_win[j] < 0 && in_valid[i] && int'(in_dest[i]) == j) m_win[j] = i;
        end
        if (m_win[j] >= 0) e_ready[m_win[j]] = 1'b1;
      end
    end
  endfunction

  function automatic void model_update();
    for (int j = 0; j < N; j++) begin
      if (m_win[j] >= 0) begin
        m_valid[j] = 1'b1;
        m_data[j]  = in_data[m_win[j]];
        m_ptr[j]   = (m_win[j] + 1) % N;
      end else if (!m_valid[j] || out_ready[j]) begin
        m_valid[j] = 1'b0;
      end
    end
  endfunction

  // First half of a cycle: combinational handshake outputs, sampled on the falling edge.
  task automatic half_a(input string tag);
    @(negedge clk);
    model_comb();
    check({tag, " in_ready"}, 64'(in_ready), 64'(e_ready));
    check({tag, " drop"}, 64'(drop), 64'(e_drop));
  endtask

  // Second half: the rising edge, then registered outputs sampled 1 time unit later.
  task automatic half_b(input string tag);
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    @(posedge clk);
    model_update();
    #1;
    for (int j = 0; j < N; j++) begin
      ev[j]       = m_valid[j];
      ed[j*W +: W] = m_data[j];
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, " out_data"}, 64'(out_data), 64'(ed));
  endtask

  task automatic tick(input string tag);
    half_a(tag);
    half_b(tag);
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = '1;
    tick("drain");
  endtask

  initial begin
    int                  order [3];
    logic [N-1:0][W-1:0] sent;
    logic [W-1:0]        cdata [N];
    bit                  first;

`ifdef XBAR_SCATTER_RR_EN
    order = '{0, 2, 4};
`else
    order = '{0, 0, 0};
`endif

    // Reset: handshake outputs forced low even with requests present.
    arst_n    = 1'b0;
    out_ready = '1;
    in_valid  = '1;
    in_data   = '0;
    for (int i = 0; i < N; i++) in_dest[i] = DW'(i);
    model_reset();
    #2;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_data", 64'(out_data), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(0));
    check("reset drop", 64'(drop), 64'(0));
    #11 arst_n = 1'b1;

    // Identity routing with random data; accepted on the first edge after release.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) in_data[i] = W'($urandom_range(0, 15));
      sent = in_data;
      half_a("ident");
      check("ident all ready", 64'(in_ready), 64'(5'h1f));
      half_b("ident");
      check("ident data", 64'(out_data), 64'(sent));
    end
    drain();

    // Contention: inputs 0, 2, 4 all aim at output 1.
    for (int i = 0; i < N; i++) begin
      cdata[i]   = W'($urandom_range(0, 15));
      in_data[i] = cdata[i];
      in_dest[i] = 3'd1;
    end
    in_valid = 5'b10101;
    for (int k = 0; k < 6; k++) begin
      half_a("cont");
      check("cont grant", 64'(in_ready), 64'(5'b1 << order[k % 3]));
      half_b("cont");
      check("cont data", 64'(out_data[1]), 64'(cdata[order[k % 3]]));
    end
    drain();

    // Backpressure on output 3.
    in_dest[0] = 3'd3; in_data[0] = 4'hA; in_valid = 5'b00001;
    tick("bp fill");
    in_valid = 5'b00010; in_dest[1] = 3'd3; in_data[1] = 4'h5;
    out_ready[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      half_a("bp hold");
      check("bp hold ready1", 64'(in_ready[1]), 64'(0));
      half_b("bp hold");
      check("bp hold data3", 64'(out_data[3]), 64'(4'hA));
      check("bp hold valid3", 64'(out_valid[3]), 64'(1));
    end
    out_ready[3] = 1'b1;
    half_a("bp release");
    check("bp release ready1", 64'(in_ready[1]), 64'(1));
    half_b("bp release");
    check("bp release data3", 64'(out_data[3]), 64'(4'h5));
    drain();

    // Out-of-range destinations, including the first invalid index and the last valid one.
    in_valid = 5'b00100; in_dest[2] = 3'd6; in_data[2] = 4'h9;
    half_a("oor");
    check("oor ready2", 64'(in_ready[2]), 64'(1));
    check("oor drop2", 64'(drop[2]), 64'(1));
    half_b("oor");
    check("oor no valid", 64'(out_valid), 64'(0));
    in_valid = 5'b11001; in_dest[0] = 3'd4; in_dest[3] = 3'd5; in_dest[4] = 3'd7;
    half_a("oor edge");
    check("oor edge drop", 64'(drop), 64'(5'b11000));
    check("oor edge ready", 64'(in_ready), 64'(5'b11001));
    half_b("oor edge");
    check("oor edge valid", 64'(out_valid), 64'(5'b10000));
    drain();

    // Random traffic; producers hold each element until the model says it was taken.
    first = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (first || !in_valid[i] || e_ready[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_dest[i]  = DW'($urandom_range(0, 7));
          in_data[i]  = W'($urandom_range(0, 15));
        end
      end
      first = 1'b0;
      for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    drain();

    // Reset mid-stream: fill every slot, move pointers off zero, then pull reset between edges.
    out_ready = '1;
    in_valid  = '1;
    for (int i = 0; i < N; i++) begin
      in_dest[i] = DW'(i);
      in_data[i] = W'($urandom_range(1, 15));
    end
    tick("pre reset fill");
    in_dest[2] = 3'd1;
    in_valid   = 5'b00100;
    tick("pre reset ptr");
    out_ready = '0;
    in_valid  = 5'b00100; in_dest[2] = 3'd6;
    #2 arst_n = 1'b0;
    model_reset();
    #2;
    check("midreset out_valid", 64'(out_valid), 64'(0));
    check("midreset out_data", 64'(out_data), 64'(0));
    check("midreset in_ready", 64'(in_ready), 64'(0));
    check("midreset drop", 64'(drop), 64'(0));
    #2 arst_n = 1'b1;
    out_ready = '1;
    for (int i = 0; i < N; i++) in_dest[i] = 3'd1;
    in_valid = 5'b10101;
    for (int k = 0; k < 3; k++) begin
      half_a("post reset");
      check("post reset grant", 64'(in_ready), 64'(5'b1 << order[k]));
      half_b("post reset");
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
